// File: rtl/sram_if_pkg.sv
// Shared element-width codes and mask helpers for the fabric-to-SRAM port.
// Masks are built at the widest supported word and truncated by the caller.
package sram_if_pkg;

  localparam int unsigned MAX_W      = 64;
  localparam int unsigned MAX_SUB_AW = 6;

  typedef enum logic [2:0] {
    CONF_1B  = 3'd0,
    CONF_2B  = 3'd1,
    CONF_4B  = 3'd2,
    CONF_8B  = 3'd3,
    CONF_16B = 3'd4,
    CONF_32B = 3'd5
  } conf_e;

  function automatic logic [2:0] conf_clamp(input logic [7:0] conf, input logic [2:0] max_conf);
    return (conf > {5'b0, max_conf}) ? max_conf : conf[2:0];
  endfunction

  // 1<<64 wraps to zero in 64-bit arithmetic, so the full-word case still yields all ones.
  function automatic logic [MAX_W-1:0] elem_mask(input logic [MAX_SUB_AW-1:0] sub, input logic [2:0] conf);
    logic [MAX_W-1:0] low;
    low = (MAX_W'(1) << (7'd1 << conf)) - MAX_W'(1);
    return low << (sub << conf);
  endfunction

endpackage

// File: rtl/sram_if_lane.sv
// Combinational element lane: bit mask, replicated write word and extracted element.
// Zero latency; no flow control of its own.
module sram_if_lane
  import sram_if_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SUB_AW = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [SUB_AW-1:0] sub_i,
  input  logic [2:0]        conf_i,
  output logic [DATA_W-1:0] mask_o,
  output logic [DATA_W-1:0] rep_o,
  output logic [DATA_W-1:0] elem_o
);

  logic [MAX_SUB_AW-1:0] sub_w;
  logic [DATA_W-1:0]     low_mask;
  logic [SUB_AW-1:0]     rep_idx_mask;

  always_comb begin
    sub_w               = '0;
    sub_w[SUB_AW-1:0]   = sub_i;
    mask_o              = DATA_W'(elem_mask(sub_w, conf_i));
    low_mask            = DATA_W'(elem_mask(MAX_SUB_AW'(0), conf_i));
    // Replication: bit i of the word takes bit (i mod W) of the element.
    for (int b = 0; b < SUB_AW; b++) rep_idx_mask[b] = (b < int'(conf_i));
    for (int i = 0; i < DATA_W; i++) rep_o[i] = word_i[SUB_AW'(i) & rep_idx_mask];
    elem_o = (word_i >> (sub_w << conf_i)) & low_mask;
  end

endmodule

// File: rtl/sram_fabric_port.sv
// Fabric-to-SRAM port: registered request, masked element write, aligned element read.
// Read data in cycle 1+RD_LAT (bypass) or 2+RD_LAT (registered); never stalls.
module sram_fabric_port
  import sram_if_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int BASE_AW = 9,
  parameter int SUB_AW  = $clog2(DATA_W),
  parameter int CONF_W  = 3,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         d_fabric_in,
  input  logic                      csb,
  input  logic                      web,
  input  logic [BASE_AW+SUB_AW-1:0] addr,
  input  logic [CONF_W-1:0]         conf,
  input  logic                      out_reg,
  output logic [DATA_W-1:0]         d_sram_in,
  output logic [DATA_W-1:0]         w_mask,
  output logic                      csb_sync,
  output logic                      web_sync,
  output logic [BASE_AW-1:0]        baseaddr_sync,
  input  logic [DATA_W-1:0]         d_sram_out,
  output logic [DATA_W-1:0]         d_fabric_out,
  output logic                      rd_valid
);

  localparam logic [2:0] MAX_CONF = 3'(SUB_AW);

  logic                csb_q, web_q;
  logic [BASE_AW-1:0]  base_q;
  logic [SUB_AW-1:0]   sub_q;
  logic [CONF_W-1:0]   conf_q;
  logic [DATA_W-1:0]   data_q;

  logic [2:0]          conf_eff;
  logic [SUB_AW-1:0]   sub_eff;
  logic                wr_en, rd_req;
  logic [DATA_W-1:0]   wr_mask, wr_elem_unused;

  logic [RD_LAT-1:0]   trk_vld_q;
  logic [SUB_AW-1:0]   trk_sub_q  [RD_LAT];
  logic [2:0]          trk_conf_q [RD_LAT];
  logic                head_vld;
  logic [DATA_W-1:0]   rd_elem, rd_mask_unused, rd_rep_unused;

  logic                out_reg_q, ovld_q, idle;
  logic [DATA_W-1:0]   hold_q, hold_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csb_q  <= 1'b1;
      web_q  <= 1'b1;
      base_q <= '0;
      sub_q  <= '0;
      conf_q <= '0;
      data_q <= '0;
    end else begin
      csb_q  <= csb;
      web_q  <= web;
      base_q <= addr[BASE_AW-1:0];
      sub_q  <= addr[BASE_AW +: SUB_AW];
      conf_q <= conf;
      data_q <= d_fabric_in;
    end
  end

  always_comb begin
    conf_eff = conf_clamp(8'(conf_q), MAX_CONF);
    for (int b = 0; b < SUB_AW; b++) sub_eff[b] = sub_q[b] & (b < SUB_AW - int'(conf_eff));
  end

  assign wr_en         = !csb_q && !web_q;
  assign rd_req        = !csb_q && web_q;
  assign csb_sync      = csb_q;
  assign web_sync      = web_q;
  assign baseaddr_sync = base_q;
  assign w_mask        = wr_en ? wr_mask : '0;

  sram_if_lane #(.DATA_W(DATA_W), .SUB_AW(SUB_AW)) u_wr_lane (
    .word_i (data_q),
    .sub_i  (sub_eff),
    .conf_i (conf_eff),
    .mask_o (wr_mask),
    .rep_o  (d_sram_in),
    .elem_o (wr_elem_unused)
  );

  // Tracker head lines up with the cycle in which the macro's dout is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        trk_sub_q[i]  <= '0;
        trk_conf_q[i] <= '0;
      end
    end else begin
      trk_vld_q[0]  <= rd_req;
      trk_sub_q[0]  <= sub_eff;
      trk_conf_q[0] <= conf_eff;
      for (int i = 1; i < RD_LAT; i++) begin
        trk_vld_q[i]  <= trk_vld_q[i-1];
        trk_sub_q[i]  <= trk_sub_q[i-1];
        trk_conf_q[i] <= trk_conf_q[i-1];
      end
    end
  end

  assign head_vld = trk_vld_q[RD_LAT-1];

  sram_if_lane #(.DATA_W(DATA_W), .SUB_AW(SUB_AW)) u_rd_lane (
    .word_i (d_sram_out),
    .sub_i  (trk_sub_q[RD_LAT-1]),
    .conf_i (trk_conf_q[RD_LAT-1]),
    .mask_o (rd_mask_unused),
    .rep_o  (rd_rep_unused),
    .elem_o (rd_elem)
  );

  // out_reg only moves when nothing is in flight, so two reads can never complete together.
  assign idle   = !(|trk_vld_q) && !ovld_q;
  assign hold_d = head_vld ? rd_elem : hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg_q <= 1'b0;
      ovld_q    <= 1'b0;
      hold_q    <= '0;
    end else begin
      if (idle) out_reg_q <= out_reg;
      ovld_q <= head_vld && out_reg_q;
      hold_q <= hold_d;
    end
  end

  assign d_fabric_out = out_reg_q ? hold_q : hold_d;
  assign rd_valid     = out_reg_q ? ovld_q : head_vld;

endmodule

// File: tb/tb_sram_fabric_port.sv
// Scoreboard bench: two ports (RD_LAT 1 and 3) on shared stimulus, each with its own macro model.
module tb_sram_fabric_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_fabric_in;
  logic        csb, web, out_reg;
  logic [13:0] addr;
  logic [2:0]  conf;

  logic [31:0] d_sram_in1, w_mask1, d_sram_out1, d_fabric_out1;
  logic        csb_sync1, web_sync1, rd_valid1;
  logic [8:0]  baseaddr_sync1;
  logic [31:0] d_sram_in3, w_mask3, d_sram_out3, d_fabric_out3;
  logic        csb_sync3, web_sync3, rd_valid3;
  logic [8:0]  baseaddr_sync3;

  always #5 clk = ~clk;

  sram_fabric_port #(.DATA_W(32), .BASE_AW(9), .CONF_W(3), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .d_fabric_in(d_fabric_in), .csb(csb), .web(web), .addr(addr),
    .conf(conf), .out_reg(out_reg), .d_sram_in(d_sram_in1), .w_mask(w_mask1),
    .csb_sync(csb_sync1), .web_sync(web_sync1), .baseaddr_sync(baseaddr_sync1),
    .d_sram_out(d_sram_out1), .d_fabric_out(d_fabric_out1), .rd_valid(rd_valid1)
  );

  sram_fabric_port #(.DATA_W(32), .BASE_AW(9), .CONF_W(3), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .d_fabric_in(d_fabric_in), .csb(csb), .web(web), .addr(addr),
    .conf(conf), .out_reg(out_reg), .d_sram_in(d_sram_in3), .w_mask(w_mask3),
    .csb_sync(csb_sync3), .web_sync(web_sync3), .baseaddr_sync(baseaddr_sync3),
    .d_sram_out(d_sram_out3), .d_fabric_out(d_fabric_out3), .rd_valid(rd_valid3)
  );

  // Macro models: capture on the edge after the pins are driven, dout RD_LAT cycles later.
  logic [31:0] mem1 [512];
  logic [31:0] mem3 [512];
  logic [31:0] ref_mem [512];
  logic [31:0] p1;
  logic [31:0] p3 [3];

  always @(posedge clk) begin
    if (!csb_sync1) begin
      if (!web_sync1) mem1[baseaddr_sync1] <= (mem1[baseaddr_sync1] & ~w_mask1) | (d_sram_in1 & w_mask1);
      else            p1 <= mem1[baseaddr_sync1];
    end
  end

  always @(posedge clk) begin
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (!csb_sync3) begin
      if (!web_sync3) mem3[baseaddr_sync3] <= (mem3[baseaddr_sync3] & ~w_mask3) | (d_sram_in3 & w_mask3);
      else            p3[0] <= mem3[baseaddr_sync3];
    end
  end

  assign d_sram_out1 = p1;
  assign d_sram_out3 = p3[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid1) begin
      if (q1.size() == 0) check_val("rd1_spurious", 64'(rd_valid1), 64'd0);
      else begin
        e1 = q1.pop_front();
        check_val("rd1_dat", 64'(d_fabric_out1), 64'(e1.dat));
        check_val("rd1_cyc", 64'(cyc), 64'(e1.due));
      end
    end else if (q1.size() != 0 && q1[0].due < cyc) begin
      check_val("rd1_late", 64'(rd_valid1), 64'd1);
      void'(q1.pop_front());
    end
    if (rd_valid3) begin
      if (q3.size() == 0) check_val("rd3_spurious", 64'(rd_valid3), 64'd0);
      else begin
        e3 = q3.pop_front();
        check_val("rd3_dat", 64'(d_fabric_out3), 64'(e3.dat));
        check_val("rd3_cyc", 64'(cyc), 64'(e3.due));
      end
    end else if (q3.size() != 0 && q3[0].due < cyc) begin
      check_val("rd3_late", 64'(rd_valid3), 64'd1);
      void'(q3.pop_front());
    end
  end

  // Drives one request for the cycle ending at the next edge and returns in that request's cycle 1.
  task automatic issue(input bit rd, input logic [8:0] base, input logic [4:0] sub,
                       input logic [2:0] cf, input logic [31:0] d, input bit rmode);
    int          ce, w, se, sh;
    logic [63:0] lm;
    logic [31:0] m, elem;
    ce = (cf > 3'd5) ? 5 : int'(cf);
    w  = 1 << ce;
    se = int'(sub) & ((32 >> ce) - 1);
    sh = se * w;
    lm = (64'd1 << w) - 64'd1;
    csb = 1'b0; web = rd; addr = {sub, base}; conf = cf; d_fabric_in = d;
    if (rd) begin
      elem = 32'((64'(ref_mem[base]) >> sh) & lm);
      q1.push_back('{elem, cyc + 2 + int'(rmode)});
      q3.push_back('{elem, cyc + 4 + int'(rmode)});
    end else begin
      m = 32'(lm << sh);
      ref_mem[base] = (ref_mem[base] & ~m) | (32'((64'(d) & lm) << sh) & m);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    csb = 1'b1; web = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r;
    for (int i = 0; i < 512; i++) begin
      mem1[i] = 32'd0; mem3[i] = 32'd0; ref_mem[i] = 32'd0;
    end
    mem1[3] = 32'hDEADBEEF; mem3[3] = 32'hDEADBEEF; ref_mem[3] = 32'hDEADBEEF;
    p1 = 32'd0;
    for (int i = 0; i < 3; i++) p3[i] = 32'd0;
    rst = 1'b1; csb = 1'b1; web = 1'b1; addr = '0; conf = '0; d_fabric_in = '0; out_reg = 1'b0;
    repeat (2) @(negedge clk);

    check_val("rst_csb_sync", 64'(csb_sync1), 64'd1);
    check_val("rst_web_sync", 64'(web_sync1), 64'd1);
    check_val("rst_baseaddr", 64'(baseaddr_sync1), 64'd0);
    check_val("rst_rd_valid", 64'(rd_valid1), 64'd0);
    check_val("rst_dout", 64'(d_fabric_out1), 64'd0);
    check_val("rst_w_mask", 64'(w_mask1), 64'd0);
    check_val("rst_csb_sync3", 64'(csb_sync3), 64'd1);
    rst = 1'b0;
    idle(2);

    // Read of a non-zero word, killed by reset in its cycle 1.
    csb = 1'b0; web = 1'b1; addr = {5'd0, 9'd3}; conf = 3'd5;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_csb_sync", 64'(csb_sync1), 64'd1);
    check_val("midrst_csb_sync3", 64'(csb_sync3), 64'd1);
    csb = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    check_val("midrst_dout", 64'(d_fabric_out1), 64'd0);
    check_val("midrst_dout3", 64'(d_fabric_out3), 64'd0);

    // Bypass: single-bit read of bit 31, then hold.
    issue(1'b0, 9'd7, 5'd0, 3'd5, 32'h80000000, 1'b0);
    issue(1'b1, 9'd7, 5'd31, 3'd0, 32'd0, 1'b0);
    idle(6);
    check_val("hold_bit", 64'(d_fabric_out1), 64'd1);
    check_val("hold_bit3", 64'(d_fabric_out3), 64'd1);

    // Byte write with junk above the element, read back the next cycle.
    issue(1'b0, 9'd5, 5'd2, 3'd3, 32'hFFFFFFA5, 1'b0);
    check_val("bw_w_mask", 64'(w_mask1), 64'h00FF0000);
    check_val("bw_din", 64'(d_sram_in1), 64'hA5A5A5A5);
    check_val("bw_csb_sync", 64'(csb_sync1), 64'd0);
    check_val("bw_web_sync", 64'(web_sync1), 64'd0);
    check_val("bw_baseaddr", 64'(baseaddr_sync1), 64'd5);
    issue(1'b1, 9'd5, 5'd0, 3'd5, 32'd0, 1'b0);
    idle(6);

    // Registered mode: back-to-back halfword reads.
    issue(1'b0, 9'd9, 5'd0, 3'd5, 32'hBEEF1234, 1'b0);
    out_reg = 1'b1;
    idle(6);
    issue(1'b1, 9'd9, 5'd0, 3'd4, 32'd0, 1'b1);
    issue(1'b1, 9'd9, 5'd1, 3'd4, 32'd0, 1'b1);
    idle(6);
    check_val("hold_hw", 64'(d_fabric_out1), 64'hBEEF);
    check_val("hold_hw3", 64'(d_fabric_out3), 64'hBEEF);

    // out_reg drops while a read sits in the tracker: that read stays registered.
    issue(1'b1, 9'd9, 5'd3, 3'd3, 32'd0, 1'b1);
    idle(1);
    out_reg = 1'b0;
    idle(8);
    issue(1'b1, 9'd9, 5'd1, 3'd4, 32'd0, 1'b0);
    issue(1'b1, 9'd9, 5'd0, 3'd4, 32'd0, 1'b0);
    idle(6);

    // Out-of-range conf clamps to the full word.
    issue(1'b0, 9'd11, 5'h1F, 3'd7, 32'hCAFEF00D, 1'b0);
    check_val("clamp_w_mask", 64'(w_mask1), 64'hFFFFFFFF);
    check_val("clamp_w_mask3", 64'(w_mask3), 64'hFFFFFFFF);
    issue(1'b1, 9'd11, 5'h15, 3'd7, 32'd0, 1'b0);
    issue(1'b1, 9'd9, 5'h0A, 3'd6, 32'd0, 1'b0);
    idle(6);

    // Random mixed traffic, bypass then registered.
    for (int mode = 0; mode < 2; mode++) begin
      out_reg = (mode == 1);
      idle(8);
      repeat (60) begin
        r = $urandom_range(0, 3);
        if (r == 0) idle(1);
        else issue(r != 1, 9'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                   3'($urandom_range(0, 7)), $urandom, mode == 1);
      end
      idle(8);
    end

    check_val("q1_drained", 64'(q1.size()), 64'd0);
    check_val("q3_drained", 64'(q3.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
